// File: rtl/nanorv32_retire_trace.sv
// Retire-point trace FIFO (FWFT, valid/ready drain) with drop accounting and end-of-test status.
// Optional status FSM enabled by defining NANORV32_TRACE_STATUS_EN.
module nanorv32_retire_trace #(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] END_PC     = 32'h0000_0100,
  parameter logic [31:0] PASS_VAL   = 32'hCAFF_E000,
  parameter logic [31:0] FAIL_VAL   = 32'hDEAD_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ret_valid,
  input  logic [31:0]           ret_pc,
  input  logic [31:0]           ret_instr,
  input  logic [31:0]           ret_a0,
  output logic                  trace_valid,
  input  logic                  trace_ready,
  output logic [31:0]           trace_pc,
  output logic [31:0]           trace_instr,
  output logic                  trace_gap,
  output logic [15:0]           drop_cnt,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic                  test_done,
  output logic [1:0]            test_code
);

  localparam int                 DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_C  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [31:0]           pc_mem_q    [DEPTH];
  logic [31:0]           instr_mem_q [DEPTH];
  logic                  gap_mem_q   [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [15:0]           drop_q, drop_d;
  logic                  gap_pend_q, gap_pend_d;
  logic                  pop, push, full;

  assign full        = (count_q == FULL_C);
  assign trace_valid = (count_q != '0);
  assign pop         = trace_valid && trace_ready;
  // A full FIFO still takes the new record when the head leaves in the same cycle.
  assign push        = ret_valid && (!full || pop);

  assign trace_pc    = pc_mem_q[rptr_q];
  assign trace_instr = instr_mem_q[rptr_q];
  assign trace_gap   = gap_mem_q[rptr_q];
  assign drop_cnt    = drop_q;
  assign fill_level  = count_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    gap_pend_d = gap_pend_q;
    if (push) begin
      wptr_d     = wptr_q + PTR_ONE;
      gap_pend_d = 1'b0;
    end else if (ret_valid) begin
      gap_pend_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
    if (pop) rptr_d = rptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      gap_pend_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      gap_pend_q <= gap_pend_d;
    end
  end

  // Storage is not reset; a write during reset is harmless since pointers/count clear.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wptr_q]    <= ret_pc;
      instr_mem_q[wptr_q] <= ret_instr;
      gap_mem_q[wptr_q]   <= gap_pend_q;
    end
  end

`ifdef NANORV32_TRACE_STATUS_EN
  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10,
    ST_UNK  = 2'b11
  } st_e;

  st_e st_q, st_d;

  always_ff @(posedge clk) begin
    if (!rst_n) st_q <= ST_RUN;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (st_q == ST_RUN && ret_valid && ret_pc == END_PC) begin
      if (ret_a0 == PASS_VAL)      st_d = ST_PASS;
      else if (ret_a0 == FAIL_VAL) st_d = ST_FAIL;
      else                         st_d = ST_UNK;
    end
  end

  always_comb begin
    test_done = (st_q != ST_RUN);
    test_code = st_q;
  end
`else
  logic unused_status;
  assign unused_status = ^{ret_a0, END_PC, PASS_VAL, FAIL_VAL};
  assign test_done     = 1'b0;
  assign test_code     = 2'b00;
`endif

endmodule

// File: doc/nanorv32_retire_trace.md
# nanorv32_retire_trace

Retired-instruction trace buffer and test-status detector for the nanorv32 core. It sits directly downstream of the CPU retire point and samples `inst_ret`, `pc_exe_r`, `instruction_r` and register x10/a0. It buffers retirement records in a FWFT FIFO drained over a valid/ready port, so benches and on-chip debug logic can consume the trace without probing CPU internals. It also flags pass/fail when execution reaches the end-of-test PC.

## Interface
Parameters:
- `DEPTH_LOG2`, 4 — FIFO depth is 2^DEPTH_LOG2 records.
- `END_PC`, 32'h0000_0100 — PC that marks end of test.
- `PASS_VAL`, 32'hCAFF_E000 — a0 value meaning pass.
- `FAIL_VAL`, 32'hDEAD_0000 — a0 value meaning fail.

Ports:
- `clk` — in, 1 — clock.
- `rst_n` — in, 1 — reset; synchronous, active-low.
- `ret_valid` — in, 1 — one instruction retired this cycle.
- `ret_pc` — in, 32 — PC of the retired instruction.
- `ret_instr` — in, 32 — encoding of the retired instruction.
- `ret_a0` — in, 32 — current x10 value.
- `trace_valid` — out, 1 — FIFO head record valid.
- `trace_ready` — in, 1 — consumer accepts the head record.
- `trace_pc` — out, 32 — head record PC.
- `trace_instr` — out, 32 — head record instruction.
- `trace_gap` — out, 1 — one or more records were dropped immediately before this record.
- `drop_cnt` — out, 16 — saturating count of dropped records.
- `fill_level` — out, DEPTH_LOG2+1 — current occupancy.
- `test_done` — out, 1 — end PC reached (sticky).
- `test_code` — out, 2 — 00 running, 01 pass, 10 fail, 11 unknown.

## Operation
- Record = {gap, pc, instr}. Storage is a register array with read/write pointers of DEPTH_LOG2 bits, which wrap naturally, plus a count of DEPTH_LOG2+1 bits.
- Pop: `trace_valid && trace_ready`. `trace_valid = (count != 0)`. Head fields are driven from the array at the read pointer. Head fields are don't-care when not valid.
- Push attempt: `ret_valid`. The push is accepted if `count < DEPTH` or a pop occurs in the same cycle.
  - When full with simultaneous pop, the push is accepted and count is unchanged.
- Rejected push: `drop_cnt` increments, saturating at 16'hFFFF, and the internal `gap_pending` bit is set.
- Accepted push: the record's gap field takes the value of `gap_pending`, and `gap_pending` is cleared.
- Pop on empty is ignored. Count changes by +1 (push only), -1 (pop only), or 0 (both or neither).
- Status FSM, evaluated only when `ret_valid && ret_pc == END_PC`:
  - RUN → PASS if `ret_a0 == PASS_VAL`.
  - RUN → FAIL if `ret_a0 == FAIL_VAL`.
  - RUN → UNKNOWN otherwise.
  - PASS, FAIL and UNKNOWN are terminal until reset. Later end-PC hits are ignored.
  - `test_done = (state != RUN)`. `test_code` encodes the state.
- X on `ret_valid` is not handled. The bench is responsible for driving it to a known value.

## Timing
- Reset values: `trace_valid` 0, `fill_level` 0, `drop_cnt` 0, `gap_pending` 0, `test_done` 0, `test_code` 00, pointers 0. Array contents are not reset.
- Latency: a push at cycle N is visible at the head (`trace_valid` = 1 if the FIFO was empty) at cycle N+1.
- Pop-to-next-head: 0 cycles. The next record is presented in the cycle after the accepting edge.
- Status: `test_done`/`test_code` assert in the cycle after the end-PC retirement edge.
- `trace_valid` and the head fields are stable while `trace_ready` = 0. A record is never withdrawn.
- Reset asserted mid-operation empties the FIFO and returns the FSM to RUN at the next edge. Pushes and pops in that cycle are discarded.

## Configuration
- `NANORV32_TRACE_STATUS_EN` defined: the status FSM is built, and `test_done`/`test_code` behave as above.
- Not defined: the FSM is removed, `test_done` is tied to 0 and `test_code` to 00. The FIFO and drop logic are unchanged.

## Test plan
- Three retirements (pc 0x0, 0x4, 0x8), `trace_ready` = 1 → three records out in order, each one cycle after push, all with `trace_gap` = 0, `fill_level` back to 0.
- `trace_ready` = 0, 18 retirements at DEPTH 16 → `fill_level` = 16, `drop_cnt` = 2. Next, ready = 1 plus one more retirement → the 17th record drained has `trace_gap` = 1, all others 0.
- FIFO full, push and pop in the same cycle → count stays 16, no drop, and the new record is drained last.
- Retire pc 0x100 with a0 = 0xCAFFE000 → `test_done` = 1, `test_code` = 01 next cycle. A later hit with 0xDEAD0000 leaves the code at 01. Repeat with 0xDEAD0000 → 10; with 0x12345678 → 11.
- 70000 drops → `drop_cnt` = 0xFFFF, saturated.
- `rst_n` low with 5 records queued → next cycle `trace_valid` = 0, `fill_level` = 0, `drop_cnt` = 0, `test_code` = 00. Without the macro, an end-PC hit keeps `test_done` = 0.
